// File: rtl/rep_umul_vec.sv
// Vector of unary (stochastic) multipliers: each lane ANDs a unary bitstream with a
// Sobol-sequence comparison against a per-lane binary weight. Optional macro: REP_UMUL_VEC_CNT_EN.

// One-dimensional Sobol generator: Gray-code ordered, so output = bit-reverse of gray(index).
module sobolrng #(
    parameter int BITWIDTH = 8
) (
    input  logic                iClk,
    input  logic                iRstN,
    input  logic                iEn,
    input  logic                iClr,
    output logic [BITWIDTH-1:0] oSobolSeq
);
    logic [BITWIDTH-1:0] idxReg;
    logic [BITWIDTH-1:0] grayIdx;

    assign grayIdx = idxReg ^ (idxReg >> 1);

    generate
        for (genvar gi = 0; gi < BITWIDTH; gi++) begin : genRev
            assign oSobolSeq[gi] = grayIdx[BITWIDTH-1-gi];
        end
    endgenerate

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            idxReg <= '0;
        end else if (iClr) begin
            idxReg <= '0;
        end else if (iEn) begin
            idxReg <= idxReg + 1'b1;
        end
    end
endmodule

module rep_umul_vec #(
    parameter int BITWIDTH = 8,
    parameter int CHANNELS = 4,
    parameter int SELW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic [CHANNELS-1:0] iA,
    input  logic [BITWIDTH-1:0] iB,
    input  logic [SELW-1:0]     iBSel,
    input  logic                iLoadB,
    input  logic                iStart,
    input  logic                iClr,
    output logic [CHANNELS-1:0] oMult,
    output logic                oBusy,
    output logic                oDone
`ifdef REP_UMUL_VEC_CNT_EN
    ,
    output logic [CHANNELS*(BITWIDTH+1)-1:0] oCnt
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

    localparam logic [BITWIDTH:0] WIN_LAST = {1'b0, {BITWIDTH{1'b1}}};

    stateT               stateReg;
    stateT               stateNext;
    logic [BITWIDTH:0]   winCntReg;
    logic                isRun;
    logic                startWin;
    logic                rngClr;
    logic                rstN;
    logic [BITWIDTH-1:0] weightReg [CHANNELS];
    logic [BITWIDTH-1:0] sobolSeq  [CHANNELS];

    assign isRun    = (stateReg == RUN);
    assign rstN     = ~iRst;
    // A window (re)starts from IDLE or straight out of DONE; abort always wins.
    assign startWin = iStart && !iClr && (stateReg != RUN);
    assign rngClr   = iClr || ((stateReg == IDLE) && iStart);
    assign oBusy    = isRun;
    assign oDone    = (stateReg == DONE) && !iClr;

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    if (iStart) stateNext = RUN;
            RUN:     if (winCntReg == WIN_LAST) stateNext = DONE;
            DONE:    stateNext = iStart ? RUN : IDLE;
            default: stateNext = IDLE;
        endcase
        if (iClr) begin
            stateNext = IDLE;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            winCntReg <= '0;
        end else if (iClr || startWin) begin
            winCntReg <= '0;
        end else if (isRun) begin
            winCntReg <= winCntReg + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : genLane
            // Out-of-range selects match no lane, so they are dropped here.
            always_ff @(posedge iClk or posedge iRst) begin
                if (iRst) begin
                    weightReg[gi] <= '0;
                end else if (iLoadB && !isRun && (32'(iBSel) == gi)) begin
                    weightReg[gi] <= iB;
                end
            end

            sobolrng #(
                .BITWIDTH (BITWIDTH)
            ) uRng (
                .iClk      (iClk),
                .iRstN     (rstN),
                .iEn       (iA[gi] && isRun),
                .iClr      (rngClr),
                .oSobolSeq (sobolSeq[gi])
            );

            assign oMult[gi] = iA[gi] && isRun && (weightReg[gi] > sobolSeq[gi]);

`ifdef REP_UMUL_VEC_CNT_EN
            logic [BITWIDTH:0] cntReg;

            always_ff @(posedge iClk or posedge iRst) begin
                if (iRst) begin
                    cntReg <= '0;
                end else if (iClr || startWin) begin
                    cntReg <= '0;
                end else if (oMult[gi]) begin
                    cntReg <= cntReg + 1'b1;
                end
            end

            assign oCnt[gi*(BITWIDTH+1) +: (BITWIDTH+1)] = cntReg;
`endif
        end
    endgenerate
endmodule

// File: tb/tb_rep_umul_vec.sv
// Directed bench for rep_umul_vec (BITWIDTH=8, CHANNELS=4); checks oCnt when REP_UMUL_VEC_CNT_EN is set.
module tb_rep_umul_vec;
    localparam int BW = 8;
    localparam int CH = 4;
    localparam int CW = BW + 1;

    logic          iClk   = 1'b0;
    logic          iRst   = 1'b1;
    logic [CH-1:0] iA     = '0;
    logic [BW-1:0] iB     = '0;
    logic [1:0]    iBSel  = '0;
    logic          iLoadB = 1'b0;
    logic          iStart = 1'b0;
    logic          iClr   = 1'b0;
    logic [CH-1:0] oMult;
    logic          oBusy;
    logic          oDone;
`ifdef REP_UMUL_VEC_CNT_EN
    logic [CH*CW-1:0] oCnt;
`endif

    rep_umul_vec #(.BITWIDTH(BW), .CHANNELS(CH)) dut (
        .iClk   (iClk),
        .iRst   (iRst),
        .iA     (iA),
        .iB     (iB),
        .iBSel  (iBSel),
        .iLoadB (iLoadB),
        .iStart (iStart),
        .iClr   (iClr),
        .oMult  (oMult),
        .oBusy  (oBusy),
        .oDone  (oDone)
`ifdef REP_UMUL_VEC_CNT_EN
        ,
        .oCnt   (oCnt)
`endif
    );

    always #5 iClk = ~iClk;

    int passCnt  = 0;
    int totalCnt = 0;
    int busyN;
    int doneN;
    int firstBusy;
    int laneN [CH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Sample mid low phase, accumulate, then advance to the next falling edge.
    task automatic tick();
        #1;
        busyN += int'(oBusy);
        doneN += int'(oDone);
        for (int i = 0; i < CH; i++) laneN[i] += int'(oMult[i]);
        @(negedge iClk);
    endtask

    task automatic loadW(input int lane, input int w);
        iLoadB = 1'b1;
        iBSel  = 2'(lane);
        iB     = 8'(w);
        @(negedge iClk);
        iLoadB = 1'b0;
    endtask

    task automatic runWindow(input logic [CH-1:0] a, input bit doStart, input int loadAt,
                             input int clrAt, input bit holdDone);
        busyN = 0;
        doneN = 0;
        firstBusy = -1;
        for (int i = 0; i < CH; i++) laneN[i] = 0;
        iA = a;
        if (doStart) begin
            iStart = 1'b1;
            tick();
            iStart = 1'b0;
        end
        for (int k = 0; k < 300; k++) begin
            iLoadB = (k == loadAt);
            if (k == loadAt) begin
                iB    = 8'd10;
                iBSel = 2'd1;
            end
            iClr   = (k == clrAt);
            iStart = (k == clrAt) || (holdDone && k == 256);
            tick();
            if (k == 0) firstBusy = busyN;
            if (doneN > 0 || (clrAt >= 0 && k >= clrAt + 3)) break;
        end
        iLoadB = 1'b0;
        iClr   = 1'b0;
        iStart = 1'b0;
    endtask

    task automatic checkLanes(input string tag, input int e0, input int e1, input int e2, input int e3);
        int exp [CH];
        exp = '{e0, e1, e2, e3};
        for (int i = 0; i < CH; i++) begin
            check($sformatf("%s_mult%0d", tag, i), 32'(laneN[i]), 32'(exp[i]));
`ifdef REP_UMUL_VEC_CNT_EN
            check($sformatf("%s_cnt%0d", tag, i), 32'(oCnt[i*CW +: CW]), 32'(exp[i]));
`endif
        end
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_busy", 32'(oBusy), 32'd0);
        check("rst_done", 32'(oDone), 32'd0);
        check("rst_mult", 32'(oMult), 32'd0);
        @(negedge iClk);
        @(negedge iClk);
        iRst = 1'b0;
        @(negedge iClk);

        // Full-rate window: counts equal the weights
        loadW(0, 0); loadW(1, 64); loadW(2, 128); loadW(3, 255);
        runWindow(4'b1111, 1'b1, -1, -1, 1'b0);
        check("w1_first_busy", 32'(firstBusy), 32'd1);
        check("w1_busy", 32'(busyN), 32'd256);
        check("w1_done", 32'(doneN), 32'd1);
        checkLanes("w1", 0, 64, 128, 255);
        @(negedge iClk);
        check("w1_idle_busy", 32'(oBusy), 32'd0);

        // Lane 2 idle for the whole window
        loadW(2, 200);
        runWindow(4'b1011, 1'b1, -1, -1, 1'b0);
        check("w2_busy", 32'(busyN), 32'd256);
        check("w2_done", 32'(doneN), 32'd1);
        checkLanes("w2", 0, 64, 0, 255);

        runWindow(4'b1111, 1'b1, -1, -1, 1'b0);
        checkLanes("w3", 0, 64, 200, 255);

        // Weight load during RUN is ignored
        runWindow(4'b1111, 1'b1, 50, -1, 1'b0);
        check("w4_done", 32'(doneN), 32'd1);
        checkLanes("w4", 0, 64, 200, 255);

        // Abort with simultaneous start at cycle 100
        runWindow(4'b1111, 1'b1, -1, 100, 1'b0);
        check("clr_busy_cycles", 32'(busyN), 32'd101);
        check("clr_done", 32'(doneN), 32'd0);
        check("clr_busy_after", 32'(oBusy), 32'd0);
        check("clr_mult_after", 32'(oMult), 32'd0);
`ifdef REP_UMUL_VEC_CNT_EN
        for (int i = 0; i < CH; i++)
            check($sformatf("clr_cnt%0d", i), 32'(oCnt[i*CW +: CW]), 32'd0);
`endif

        // Asynchronous reset mid-window
        iA = 4'b1111;
        iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        repeat (30) @(negedge iClk);
        check("pre_rst_busy", 32'(oBusy), 32'd1);
        #2 iRst = 1'b1;
        #1;
        check("arst_busy", 32'(oBusy), 32'd0);
        check("arst_mult", 32'(oMult), 32'd0);
        check("arst_done", 32'(oDone), 32'd0);
        @(negedge iClk);
        iRst = 1'b0;
        @(negedge iClk);
        runWindow(4'b1111, 1'b1, -1, -1, 1'b0);
        check("post_rst_busy", 32'(busyN), 32'd256);
        checkLanes("post_rst", 0, 0, 0, 0);

        // Start held in DONE: back-to-back windows with identical counts
        loadW(0, 0); loadW(1, 64); loadW(2, 128); loadW(3, 255);
        runWindow(4'b1111, 1'b1, -1, -1, 1'b1);
        check("b2b1_done", 32'(doneN), 32'd1);
        checkLanes("b2b1", 0, 64, 128, 255);
        runWindow(4'b1111, 1'b0, -1, -1, 1'b0);
        check("b2b2_first_busy", 32'(firstBusy), 32'd1);
        check("b2b2_busy", 32'(busyN), 32'd256);
        check("b2b2_done", 32'(doneN), 32'd1);
        checkLanes("b2b2", 0, 64, 128, 255);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
